// File: rtl/csu_pkg.sv
// Shared definitions for the DAC current-source-unit power sequencer.
// Provides the FSM state encoding, default array geometry, the DAC code
// width and the saturated full-scale code.
package csu_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_BIAS   = 3'd1,
    ST_RAMP   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_RAMPDN = 3'd4
  } csu_state_e;

  localparam int unsigned N_THERM_DEF = 17;
  localparam int unsigned N_BIN_DEF   = 6;
  localparam int unsigned CODE_W      = 12;

  // 17 thermometer units, all binary units and the half-LSB unit on.
  localparam logic [CODE_W-1:0] FULL_SCALE = 12'd2303;

endpackage

// File: rtl/csu_code_decoder.sv
// Combinational DAC code decoder.
// Splits a code into thermometer count, binary enables and half-LSB enable,
// replacing any code whose thermometer field exceeds N_THERM by full scale.
// Ports:
//   code      in   CODE_W  raw DAC code ([MSBs] therm count, [N_BIN:1] binary, [0] half-LSB)
//   tgt_cnt   out  CNT_W   thermometer unit count after saturation
//   tgt_bin   out  N_BIN   binary unit enables after saturation
//   tgt_half  out  1       half-LSB unit enable after saturation
//   sat       out  1       code was out of range and has been saturated
module csu_code_decoder
  import csu_pkg::*;
#(
  parameter int unsigned N_THERM = N_THERM_DEF,
  parameter int unsigned N_BIN   = N_BIN_DEF,
  localparam int unsigned CNT_W  = CODE_W - 1 - N_BIN
) (
  input  logic [CODE_W-1:0] code,
  output logic [CNT_W-1:0]  tgt_cnt,
  output logic [N_BIN-1:0]  tgt_bin,
  output logic              tgt_half,
  output logic              sat
);

  logic [CODE_W-1:0] eff_code;

  always_comb begin
    sat      = 32'(code[CODE_W-1 -: CNT_W]) > N_THERM;
    eff_code = sat ? FULL_SCALE : code;
    tgt_cnt  = eff_code[CODE_W-1 -: CNT_W];
    tgt_bin  = eff_code[N_BIN:1];
    tgt_half = eff_code[0];
  end

endmodule

// File: rtl/csu_power_sequencer.sv
// Power sequencer for the DAC current-source-unit array.
// Powers the bias up, waits for it to settle, ramps thermometer units on one
// at a time, tracks new codes while active, and ramps units off again before
// removing bias. Also gates the analog test-bus selection.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   enable         1 = request array active, 0 = request power-down
//   code_valid/ready  code handshake; code is the 12-bit DAC code
//   atb_sel_req    requested test-bus selection
//   pdb            bias power-down-bar
//   atb_ena        test-bus enable (follows atb_sel_req only while ACTIVE)
//   therm_en       thermometer unit enables (lowest active-count units on)
//   bin_en         binary unit enables
//   bin0_red_en    half-LSB unit enable
//   state          current FSM state (OFF/BIAS/RAMP/ACTIVE/RAMPDN)
//   sat_err        one-cycle pulse after an out-of-range code is accepted
module csu_power_sequencer
  import csu_pkg::*;
#(
  parameter int unsigned N_THERM       = N_THERM_DEF,
  parameter int unsigned N_BIN         = N_BIN_DEF,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned RAMP_STEP     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               code_valid,
  output logic               code_ready,
  input  logic [CODE_W-1:0]  code,
  input  logic [1:0]         atb_sel_req,
  output logic               pdb,
  output logic [1:0]         atb_ena,
  output logic [N_THERM-1:0] therm_en,
  output logic [N_BIN-1:0]   bin_en,
  output logic               bin0_red_en,
  output logic [2:0]         state,
  output logic               sat_err
);

  localparam int unsigned CNT_W = CODE_W - 1 - N_BIN;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned STP_W = $clog2(RAMP_STEP + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [STP_W-1:0] STEP_LAST   = STP_W'(RAMP_STEP - 1);

  csu_state_e        state_q;
  logic [CNT_W-1:0]  act_cnt;
  logic [CNT_W-1:0]  tgt_cnt;
  logic [N_BIN-1:0]  tgt_bin;
  logic              tgt_half;
  logic [SET_W-1:0]  settle_tmr;
  logic [STP_W-1:0]  step_tmr;

  logic [CNT_W-1:0]  dec_cnt;
  logic [N_BIN-1:0]  dec_bin;
  logic              dec_half;
  logic              dec_sat;
  logic              accept;

  // Target as it will be after this edge; lets a code accepted in the last
  // BIAS cycle still be applied at RAMP entry.
  logic [N_BIN-1:0]  nxt_bin;
  logic              nxt_half;

  csu_code_decoder #(
    .N_THERM (N_THERM),
    .N_BIN   (N_BIN)
  ) u_dec (
    .code     (code),
    .tgt_cnt  (dec_cnt),
    .tgt_bin  (dec_bin),
    .tgt_half (dec_half),
    .sat      (dec_sat)
  );

  function automatic logic [N_THERM-1:0] therm_mask(input logic [CNT_W-1:0] cnt);
    logic [N_THERM-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N_THERM; i++) m[i] = (i < 32'(cnt));
    return m;
  endfunction

  always_comb begin
    accept   = code_valid && code_ready;
    nxt_bin  = accept ? dec_bin  : tgt_bin;
    nxt_half = accept ? dec_half : tgt_half;
  end

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      pdb         <= 1'b0;
      code_ready  <= 1'b1;
      atb_ena     <= '0;
      therm_en    <= '0;
      bin_en      <= '0;
      bin0_red_en <= 1'b0;
      sat_err     <= 1'b0;
      act_cnt     <= '0;
      tgt_cnt     <= '0;
      tgt_bin     <= '0;
      tgt_half    <= 1'b0;
      settle_tmr  <= '0;
      step_tmr    <= '0;
    end else begin
      sat_err <= accept && dec_sat;
      atb_ena <= '0;
      if (accept) begin
        tgt_cnt  <= dec_cnt;
        tgt_bin  <= dec_bin;
        tgt_half <= dec_half;
      end

      case (state_q)
        ST_OFF: begin
          pdb         <= 1'b0;
          therm_en    <= '0;
          bin_en      <= '0;
          bin0_red_en <= 1'b0;
          act_cnt     <= '0;
          if (enable) begin
            state_q    <= ST_BIAS;
            pdb        <= 1'b1;
            settle_tmr <= '0;
          end
        end

        ST_BIAS: begin
          if (!enable) begin
            state_q    <= ST_OFF;
            pdb        <= 1'b0;
          end else if (settle_tmr == SETTLE_LAST) begin
            state_q     <= ST_RAMP;
            code_ready  <= 1'b0;
            step_tmr    <= '0;
            act_cnt     <= '0;
            bin_en      <= nxt_bin;
            bin0_red_en <= nxt_half;
          end else begin
            settle_tmr <= settle_tmr + SET_W'(1);
          end
        end

        ST_RAMP: begin
          if (!enable) begin
            state_q     <= ST_RAMPDN;
            step_tmr    <= '0;
            bin_en      <= '0;
            bin0_red_en <= 1'b0;
          end else if (act_cnt == tgt_cnt) begin
            state_q    <= ST_ACTIVE;
            code_ready <= 1'b1;
          end else if (step_tmr == STEP_LAST) begin
            step_tmr <= '0;
            act_cnt  <= act_cnt + CNT_ONE;
            therm_en <= therm_mask(act_cnt + CNT_ONE);
          end else begin
            step_tmr <= step_tmr + STP_W'(1);
          end
        end

        ST_ACTIVE: begin
          // Power-down wins over a same-cycle accept: the code is kept as
          // target but never reaches the array.
          if (!enable) begin
            state_q     <= ST_RAMPDN;
            code_ready  <= 1'b0;
            step_tmr    <= '0;
            bin_en      <= '0;
            bin0_red_en <= 1'b0;
          end else begin
            atb_ena <= atb_sel_req;
            if (accept) begin
              act_cnt     <= dec_cnt;
              therm_en    <= therm_mask(dec_cnt);
              bin_en      <= dec_bin;
              bin0_red_en <= dec_half;
            end
          end
        end

        ST_RAMPDN: begin
          if (act_cnt == '0) begin
            state_q    <= ST_OFF;
            pdb        <= 1'b0;
            code_ready <= 1'b1;
          end else if (step_tmr == STEP_LAST) begin
            step_tmr <= '0;
            act_cnt  <= act_cnt - CNT_ONE;
            therm_en <= therm_mask(act_cnt - CNT_ONE);
          end else begin
            step_tmr <= step_tmr + STP_W'(1);
          end
        end

        default: begin
          state_q    <= ST_OFF;
          pdb        <= 1'b0;
          code_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csu_power_sequencer.sv
module tb_csu_power_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        code_valid;
  logic        code_ready;
  logic [11:0] code;
  logic [1:0]  atb_sel_req;
  logic        pdb;
  logic [1:0]  atb_ena;
  logic [16:0] therm_en;
  logic [5:0]  bin_en;
  logic        bin0_red_en;
  logic [2:0]  state;
  logic        sat_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csu_power_sequencer #(
    .N_THERM       (17),
    .N_BIN         (6),
    .SETTLE_CYCLES (64),
    .RAMP_STEP     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .code        (code),
    .atb_sel_req (atb_sel_req),
    .pdb         (pdb),
    .atb_ena     (atb_ena),
    .therm_en    (therm_en),
    .bin_en      (bin_en),
    .bin0_red_en (bin0_red_en),
    .state       (state),
    .sat_err     (sat_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [16:0] ramp_exp [5];

  initial begin
    ramp_exp[0] = 17'h1; ramp_exp[1] = 17'h3; ramp_exp[2] = 17'h7;
    ramp_exp[3] = 17'hF; ramp_exp[4] = 17'h1F;

    rst = 1'b1; enable = 1'b0; code_valid = 1'b0; code = '0; atb_sel_req = 2'b00;
    step(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_pdb", 32'(pdb), 0);
    chk("rst_therm", 32'(therm_en), 0);
    chk("rst_bin", 32'(bin_en), 0);
    chk("rst_ready", 32'(code_ready), 1);
    chk("rst_sat", 32'(sat_err), 0);
    rst = 1'b0;

    // Power-up with 0x285: count 5, bin 000010, half-LSB 1; atb request in OFF.
    code = 12'h285; code_valid = 1'b1; enable = 1'b1; atb_sel_req = 2'b10;
    step(1);
    chk("up_pdb", 32'(pdb), 1);
    chk("up_state_bias", 32'(state), 1);
    chk("off_atb", 32'(atb_ena), 0);
    code_valid = 1'b0;
    step(63);
    chk("bias_last_state", 32'(state), 1);
    chk("bias_last_bin", 32'(bin_en), 0);
    step(1);
    chk("ramp_state", 32'(state), 2);
    chk("ramp_bin", 32'(bin_en), 6'b000010);
    chk("ramp_half", 32'(bin0_red_en), 1);
    chk("ramp_therm0", 32'(therm_en), 0);
    chk("ramp_ready", 32'(code_ready), 0);
    step(3);
    chk("ramp_therm_hold", 32'(therm_en), 0);
    step(1);
    chk("ramp_therm_1", 32'(therm_en), 32'(ramp_exp[0]));
    for (int i = 1; i < 5; i++) begin
      step(4);
      chk("ramp_therm_n", 32'(therm_en), 32'(ramp_exp[i]));
    end
    chk("ramp_last_state", 32'(state), 2);
    step(1);
    chk("active_state", 32'(state), 3);
    chk("active_ready", 32'(code_ready), 1);
    chk("active_entry_atb", 32'(atb_ena), 0);
    step(1);
    chk("active_atb", 32'(atb_ena), 2'b10);

    // Saturating code in ACTIVE.
    code = 12'hFFF; code_valid = 1'b1;
    step(1);
    code_valid = 1'b0;
    chk("sat_therm", 32'(therm_en), 17'h1FFFF);
    chk("sat_bin", 32'(bin_en), 6'h3F);
    chk("sat_half", 32'(bin0_red_en), 1);
    chk("sat_pulse", 32'(sat_err), 1);
    step(1);
    chk("sat_pulse_end", 32'(sat_err), 0);

    // Power-down from full scale.
    enable = 1'b0;
    step(1);
    chk("dn_state", 32'(state), 4);
    chk("dn_atb", 32'(atb_ena), 0);
    chk("dn_bin", 32'(bin_en), 0);
    chk("dn_half", 32'(bin0_red_en), 0);
    chk("dn_therm_hold", 32'(therm_en), 17'h1FFFF);
    chk("dn_ready", 32'(code_ready), 0);
    step(4);
    chk("dn_therm_16", 32'(therm_en), 17'h0FFFF);
    step(64);
    chk("dn_therm_0", 32'(therm_en), 0);
    chk("dn_pdb_still", 32'(pdb), 1);
    step(1);
    chk("dn_off_state", 32'(state), 0);
    chk("dn_off_pdb", 32'(pdb), 0);

    // Code held valid through RAMP: refused until ACTIVE.
    code = 12'h100; code_valid = 1'b1; enable = 1'b1;
    step(1);
    code_valid = 1'b0;
    step(64);
    chk("r3_ramp_state", 32'(state), 2);
    code = 12'h080; code_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("r3_ready_low", 32'(code_ready), 0);
    end
    chk("r3_therm_3", 32'(therm_en), 17'h3);
    step(1);
    chk("r3_active", 32'(state), 3);
    chk("r3_ready_high", 32'(code_ready), 1);
    step(1);
    code_valid = 1'b0;
    chk("r3_therm_1", 32'(therm_en), 17'h1);

    // Back to OFF, then ramp and abort at count 3.
    enable = 1'b0;
    step(6);
    chk("r5_off", 32'(state), 0);
    code = 12'h285; code_valid = 1'b1; enable = 1'b1;
    step(1);
    code_valid = 1'b0;
    step(76);
    chk("r5_count3", 32'(therm_en), 17'h7);
    enable = 1'b0;
    step(1);
    chk("r5_dn_state", 32'(state), 4);
    chk("r5_dn_bin", 32'(bin_en), 0);
    step(3);
    chk("r5_therm_7", 32'(therm_en), 17'h7);
    step(1);
    chk("r5_therm_3", 32'(therm_en), 17'h3);
    enable = 1'b1;
    step(4);
    chk("r5_therm_1", 32'(therm_en), 17'h1);
    step(4);
    chk("r5_therm_0", 32'(therm_en), 0);
    chk("r5_ignore_en", 32'(state), 4);
    step(1);
    chk("r5_off_state", 32'(state), 0);
    chk("r5_off_pdb", 32'(pdb), 0);
    step(1);
    chk("r5_rebias", 32'(state), 1);
    chk("r5_rebias_pdb", 32'(pdb), 1);

    // Zero target: ACTIVE right after the first RAMP cycle.
    code = 12'h000; code_valid = 1'b1;
    step(1);
    code_valid = 1'b0;
    step(63);
    chk("z_ramp", 32'(state), 2);
    chk("z_bin", 32'(bin_en), 0);
    chk("z_half", 32'(bin0_red_en), 0);
    step(1);
    chk("z_active", 32'(state), 3);
    code = 12'h285; code_valid = 1'b1;
    step(1);
    chk("act_therm_5", 32'(therm_en), 17'h1F);
    chk("act_atb", 32'(atb_ena), 2'b10);
    code = 12'h881;
    step(1);
    chk("edge17_therm", 32'(therm_en), 17'h1FFFF);
    chk("edge17_bin", 32'(bin_en), 0);
    chk("edge17_nosat", 32'(sat_err), 0);
    code = 12'h900;
    step(1);
    code_valid = 1'b0;
    chk("edge18_bin", 32'(bin_en), 6'h3F);
    chk("edge18_sat", 32'(sat_err), 1);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_pdb", 32'(pdb), 0);
    chk("arst_therm", 32'(therm_en), 0);
    chk("arst_bin", 32'(bin_en), 0);
    chk("arst_atb", 32'(atb_ena), 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
